// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM access arbiter: FSM state encoding,
// RAM bus geometry and read/write opcode values.
package ram_arb_pkg;

  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 4;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Pick the RAM occupancy for the latched operation.
  function automatic int op_latency(input logic rw, input int rd_lat, input int wr_lat);
    int lat;
    if (rw == RW_WRITE) begin
      lat = wr_lat;
    end else begin
      lat = rd_lat;
    end
    return lat;
  endfunction

endpackage

// File: rtl/ram_access_arbiter_rr.sv
// Combinational round-robin picker: the first requester after the pointer,
// wrapping, wins. Produces a one-hot winner, its index and a valid flag.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] win_onehot_o,
  output logic [IDX_W-1:0] win_idx_o,
  output logic             win_valid_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan offsets 1..N_REQ from the pointer so the pointer itself has lowest priority.
  always_comb begin
    win_onehot_o = '0;
    win_idx_o    = '0;
    win_valid_o  = 1'b0;
    cand         = 0;
    cand_idx     = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand     = (int'(ptr_i) + off) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_valid_o && req_i[cand_idx]) begin
        win_valid_o            = 1'b1;
        win_onehot_o[cand_idx] = 1'b1;
        win_idx_o              = cand_idx;
      end else begin
        win_valid_o = win_valid_o;
      end
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one RAM port between N_REQ requesters: round-robin pick, one transaction
// in flight, sequences ram_EN/ram_RW and returns read data with a done pulse.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int N_REQ  = 2,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              req_rw,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              done,
  output logic [DATA_W-1:0]             rdata,
  output logic                          busy,
  output logic                          ram_RW,
  output logic                          ram_EN,
  output logic [ADDR_W-1:0]             ram_address_bus,
  output logic [DATA_W-1:0]             ram_data_bus_out,
  input  logic [DATA_W-1:0]             ram_data_bus_in
);

  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  if (RD_LAT < 1 || WR_LAT < 1 || N_REQ < 2) begin : g_bad_params
    $error("ram_access_arbiter: RD_LAT and WR_LAT must be >= 1 and N_REQ >= 2");
  end

  state_t              state_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [N_REQ-1:0]    owner_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [N_REQ-1:0]    gnt_q;
  logic [N_REQ-1:0]    done_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                busy_q;
  logic                rw_q;
  logic                en_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   dout_q;

  logic [N_REQ-1:0]    win_onehot_s;
  logic [IDX_W-1:0]    win_idx_s;
  logic                win_valid_s;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i        (req),
    .ptr_i        (ptr_q),
    .win_onehot_o (win_onehot_s),
    .win_idx_o    (win_idx_s),
    .win_valid_o  (win_valid_s)
  );

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(N_REQ - 1);
      owner_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      rw_q    <= RW_READ;
      en_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid_s) begin
            state_q <= ACCESS;
            ptr_q   <= win_idx_s;
            owner_q <= win_onehot_s;
            gnt_q   <= win_onehot_s;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            rw_q    <= req_rw[win_idx_s];
            addr_q  <= req_addr[win_idx_s];
            // Reads drive zero on the write bus so the RAM never sees stale data.
            if (req_rw[win_idx_s] == RW_WRITE) begin
              dout_q <= req_wdata[win_idx_s];
            end else begin
              dout_q <= '0;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          state_q <= WAIT;
          gnt_q   <= '0;
          en_q    <= 1'b0;
          cnt_q   <= CNT_W'(op_latency(rw_q, RD_LAT, WR_LAT));
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DONE;
            done_q  <= owner_q;
            if (rw_q == RW_READ) begin
              rdata_q <= ram_data_bus_in;
            end else begin
              rdata_q <= rdata_q;
            end
          end else begin
            state_q <= WAIT;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          done_q  <= '0;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt              = gnt_q;
  assign done             = done_q;
  assign rdata            = rdata_q;
  assign busy             = busy_q;
  assign ram_RW           = rw_q;
  assign ram_EN           = en_q;
  assign ram_address_bus  = addr_q;
  assign ram_data_bus_out = dout_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: a per-cycle vector table for the
// single read/write/wrap cases plus sequences for contention, latency and reset.
module tb_ram_access_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       req_a, rw_a, gnt_a, done_a;
  logic [1:0][7:0]  addr_a;
  logic [1:0][3:0]  wd_a;
  logic [3:0]       rdata_a, ram_dout_a, ram_din_a;
  logic             busy_a, ram_rw_a, ram_en_a;
  logic [7:0]       ram_addr_a;

  logic [1:0]       req_b, rw_b, gnt_b, done_b;
  logic [1:0][7:0]  addr_b;
  logic [1:0][3:0]  wd_b;
  logic [3:0]       rdata_b, ram_dout_b, ram_din_b;
  logic             busy_b, ram_rw_b, ram_en_b;
  logic [7:0]       ram_addr_b;

  ram_access_arbiter #(.ADDR_W(8), .DATA_W(4), .N_REQ(2), .RD_LAT(1), .WR_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .req_rw(rw_a), .req_addr(addr_a), .req_wdata(wd_a),
    .gnt(gnt_a), .done(done_a), .rdata(rdata_a), .busy(busy_a), .ram_RW(ram_rw_a),
    .ram_EN(ram_en_a), .ram_address_bus(ram_addr_a), .ram_data_bus_out(ram_dout_a),
    .ram_data_bus_in(ram_din_a));

  ram_access_arbiter #(.ADDR_W(8), .DATA_W(4), .N_REQ(2), .RD_LAT(3), .WR_LAT(1)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .req_rw(rw_b), .req_addr(addr_b), .req_wdata(wd_b),
    .gnt(gnt_b), .done(done_b), .rdata(rdata_b), .busy(busy_b), .ram_RW(ram_rw_b),
    .ram_EN(ram_en_b), .ram_address_bus(ram_addr_b), .ram_data_bus_out(ram_dout_b),
    .ram_data_bus_in(ram_din_b));

  // RAM contents seen by each instance; data appears only in the cycle it is due.
  function automatic logic [3:0] rom_a(input logic [7:0] a);
    case (a)
      8'h3C:   return 4'hA;
      8'hFF:   return 4'h6;
      8'h00:   return 4'h9;
      default: return 4'h3;
    endcase
  endfunction

  function automatic logic [3:0] rom_b(input logic [7:0] a);
    if (a == 8'h3C) return 4'hB;
    else return 4'h2;
  endfunction

  logic       pv_a;
  logic [3:0] pd_a;
  logic [2:0] pv_b;
  logic [3:0] pd_b0, pd_b1, pd_b2;

  always @(posedge clk) begin
    pv_a  <= ram_en_a && !ram_rw_a;
    pd_a  <= rom_a(ram_addr_a);
    pv_b  <= {pv_b[1:0], ram_en_b && !ram_rw_b};
    pd_b0 <= rom_b(ram_addr_b);
    pd_b1 <= pd_b0;
    pd_b2 <= pd_b1;
  end

  assign ram_din_a = pv_a    ? pd_a  : 4'h0;
  assign ram_din_b = pv_b[2] ? pd_b2 : 4'h0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] req, rw;
    logic [7:0] a0, a1;
    logic [3:0] w0, w1;
    logic [1:0] gnt, done;
    logic       busy, en, rwo;
    logic [7:0] addr;
    logic [3:0] dout, rdata;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] req, rw, input logic [7:0] a0, a1,
                              input logic [3:0] w0, w1, input logic [1:0] gnt, dn,
                              input logic busy, en, rwo, input logic [7:0] addr,
                              input logic [3:0] dout, rdata);
    vec_t v;
    v.req = req; v.rw = rw; v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1;
    v.gnt = gnt; v.done = dn; v.busy = busy; v.en = en; v.rwo = rwo;
    v.addr = addr; v.dout = dout; v.rdata = rdata;
    return v;
  endfunction

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic chk_zero_a(input string nm);
    chk({nm, ".gnt"},   32'(gnt_a),      32'h0);
    chk({nm, ".done"},  32'(done_a),     32'h0);
    chk({nm, ".busy"},  32'(busy_a),     32'h0);
    chk({nm, ".en"},    32'(ram_en_a),   32'h0);
    chk({nm, ".rw"},    32'(ram_rw_a),   32'h0);
    chk({nm, ".addr"},  32'(ram_addr_a), 32'h0);
    chk({nm, ".dout"},  32'(ram_dout_a), 32'h0);
    chk({nm, ".rdata"}, 32'(rdata_a),    32'h0);
  endtask

  logic [1:0] order[4];
  int         ng;
  int         cyc;

  initial begin
    // Single read (3C), single write (F0/5), then FF and 00 back to back.
    vecs[0]  = mk(2'b01, 2'b00, 8'h3C, 8'h00, 4'h0, 4'h0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 8'h3C, 4'h0, 4'h0);
    vecs[1]  = mk(2'b01, 2'b00, 8'h3C, 8'h00, 4'h0, 4'h0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 8'h3C, 4'h0, 4'h0);
    vecs[2]  = mk(2'b00, 2'b00, 8'h00, 8'h00, 4'h0, 4'h0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 8'h3C, 4'h0, 4'hA);
    vecs[3]  = mk(2'b00, 2'b00, 8'h00, 8'h00, 4'h0, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h3C, 4'h0, 4'hA);
    vecs[4]  = mk(2'b10, 2'b10, 8'h00, 8'hF0, 4'h0, 4'h5, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 8'hF0, 4'h5, 4'hA);
    vecs[5]  = mk(2'b10, 2'b10, 8'h00, 8'hF0, 4'h0, 4'h5, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 8'hF0, 4'h5, 4'hA);
    vecs[6]  = mk(2'b00, 2'b00, 8'h00, 8'h00, 4'h0, 4'h0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b1, 8'hF0, 4'h5, 4'hA);
    vecs[7]  = mk(2'b00, 2'b00, 8'h00, 8'h00, 4'h0, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 8'hF0, 4'h5, 4'hA);
    vecs[8]  = mk(2'b01, 2'b00, 8'hFF, 8'h00, 4'h0, 4'h0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 8'hFF, 4'h0, 4'hA);
    vecs[9]  = mk(2'b01, 2'b00, 8'hFF, 8'h00, 4'h0, 4'h0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 8'hFF, 4'h0, 4'hA);
    vecs[10] = mk(2'b01, 2'b00, 8'h00, 8'h00, 4'h0, 4'h0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 8'hFF, 4'h0, 4'h6);
    vecs[11] = mk(2'b01, 2'b00, 8'h00, 8'h00, 4'h0, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'hFF, 4'h0, 4'h6);
    vecs[12] = mk(2'b01, 2'b00, 8'h00, 8'h00, 4'h0, 4'h0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 4'h6);
    vecs[13] = mk(2'b00, 2'b00, 8'h00, 8'h00, 4'h0, 4'h0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 4'h6);
    vecs[14] = mk(2'b00, 2'b00, 8'h00, 8'h00, 4'h0, 4'h0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 4'h9);
    vecs[15] = mk(2'b00, 2'b00, 8'h00, 8'h00, 4'h0, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 4'h9);
    vecs[16] = mk(2'b00, 2'b00, 8'h00, 8'h00, 4'h0, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 4'h9);

    rst = 1'b1;
    req_a = 2'b00; rw_a = 2'b00; addr_a = '0; wd_a = '0;
    req_b = 2'b00; rw_b = 2'b00; addr_b = '0; wd_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero_a("reset_a");
    chk("reset_b.en",   32'(ram_en_b), 32'h0);
    chk("reset_b.busy", 32'(busy_b),   32'h0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      req_a = vecs[i].req; rw_a = vecs[i].rw;
      addr_a[0] = vecs[i].a0; addr_a[1] = vecs[i].a1;
      wd_a[0] = vecs[i].w0;   wd_a[1] = vecs[i].w1;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d.gnt", i),   32'(gnt_a),      32'(vecs[i].gnt));
      chk($sformatf("v%0d.done", i),  32'(done_a),     32'(vecs[i].done));
      chk($sformatf("v%0d.busy", i),  32'(busy_a),     32'(vecs[i].busy));
      chk($sformatf("v%0d.en", i),    32'(ram_en_a),   32'(vecs[i].en));
      chk($sformatf("v%0d.rw", i),    32'(ram_rw_a),   32'(vecs[i].rwo));
      chk($sformatf("v%0d.addr", i),  32'(ram_addr_a), 32'(vecs[i].addr));
      chk($sformatf("v%0d.dout", i),  32'(ram_dout_a), 32'(vecs[i].dout));
      chk($sformatf("v%0d.rdata", i), 32'(rdata_a),    32'(vecs[i].rdata));
    end

    // RD_LAT=3 read: ram_EN only in C1, done and data in C5.
    req_b = 2'b01; rw_b = 2'b00; addr_b[0] = 8'h3C;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      @(negedge clk);
      req_b = 2'b00;
      chk($sformatf("lat3.c%0d.en", k),   32'(ram_en_b), 32'(k == 1));
      chk($sformatf("lat3.c%0d.done", k), 32'(done_b),   (k == 5) ? 32'h1 : 32'h0);
      chk($sformatf("lat3.c%0d.busy", k), 32'(busy_b),   32'(k <= 5));
      if (k == 5) chk("lat3.rdata", 32'(rdata_b), 32'hB);
    end

    // Contention: both requesters held high from reset.
    rst = 1'b1;
    req_a = 2'b11; rw_a = 2'b10;
    addr_a[0] = 8'h3C; addr_a[1] = 8'h10; wd_a[0] = 4'h0; wd_a[1] = 4'h7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ng = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (gnt_a != 2'b00) begin
        chk($sformatf("cont.onehot%0d", ng), 32'($onehot(gnt_a)), 32'h1);
        order[ng] = gnt_a;
        ng++;
      end
    end
    chk("cont.count", 32'(ng), 32'd4);
    for (int j = 0; j < ng; j++) begin
      chk($sformatf("cont.order%0d", j), 32'(order[j]), (j % 2 == 0) ? 32'h1 : 32'h2);
    end
    req_a = 2'b00;
    cyc = 0;
    while (busy_a && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("cont.drain", 32'(busy_a), 32'h0);

    // Reset in the middle of a read: no done afterwards.
    req_a = 2'b01; rw_a = 2'b00; addr_a[0] = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid.en", 32'(ram_en_a), 32'h1);
    req_a = 2'b00;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk_zero_a($sformatf("rstmid%0d", k));
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rstmid.post%0d.done", k), 32'(done_a),   32'h0);
      chk($sformatf("rstmid.post%0d.en", k),   32'(ram_en_a), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
